// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM state encoding and default PE array dimensions
package cnn_pkg;
    localparam int MAX_FILTERNUM = 64;
    localparam int MAX_KERNELNUM = 8;
    typedef enum logic [2:0] {IDLE, CHECK, ERR, LOAD, COMPUTE, DONE} state_t;
endpackage

// File: rtl/pe_onehot_addr.sv
// pe_onehot_addr: maps a row-major (row, kern) PE coordinate to a one-hot write enable
module pe_onehot_addr #(
    parameter int MAX_FILTERNUM = cnn_pkg::MAX_FILTERNUM,
    parameter int MAX_KERNELNUM = cnn_pkg::MAX_KERNELNUM,
    parameter int W             = $clog2(MAX_FILTERNUM) + 1
) (
    input  logic [W-1:0]             row,
    input  logic [W-1:0]             kern,
    input  logic                     en,
    output logic [MAX_FILTERNUM-1:0] onehot
);
    logic [W-1:0]             idx;
    logic [MAX_FILTERNUM-1:0] one;
    // row stride equals the number of PEs per row
    always_comb begin
        one    = {{(MAX_FILTERNUM-1){1'b0}}, 1'b1};
        idx    = row * W'(MAX_KERNELNUM) + kern;
        onehot = en ? one << idx : '0;
    end
endmodule

// File: rtl/pe_filter_load_ctrl.sv
// pe_filter_load_ctrl: validates a filter config, streams filter words into PEs, hands over to compute
module pe_filter_load_ctrl #(
    parameter int MAX_FILTERNUM   = cnn_pkg::MAX_FILTERNUM,
    parameter int MAX_KERNELNUM   = cnn_pkg::MAX_KERNELNUM,
    parameter int FILTERNUM_WIDTH = $clog2(MAX_FILTERNUM) + 1,
    parameter int KERNELNUM_WIDTH = $clog2(MAX_KERNELNUM) + 1,
    parameter int DATA_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [FILTERNUM_WIDTH-1:0] num_filter,
    input  logic [KERNELNUM_WIDTH-1:0] num_kernel,
    output logic                       busy,
    output logic                       cfg_err,
    input  logic                       flt_valid,
    output logic                       flt_ready,
    input  logic [DATA_WIDTH-1:0]      flt_data,
    output logic [MAX_FILTERNUM-1:0]   pe_we,
    output logic [DATA_WIDTH-1:0]      pe_wdata,
    output logic [FILTERNUM_WIDTH-1:0] filter_cnt,
    output logic                       filter_load,
    output logic                       compute_start,
    input  logic                       compute_done,
    output logic                       done
);
    import cnn_pkg::*;
    localparam int FW = FILTERNUM_WIDTH;
    localparam logic [FW-1:0] ROWS_MAX = FW'(MAX_FILTERNUM / MAX_KERNELNUM);
    state_t               state, nxt;
    logic [FW-1:0]        nf_q, nk_q, rem, rows, row, kern;
    logic                 accept, last, bad_cfg;
    logic [MAX_FILTERNUM-1:0] we_nxt;
    assign accept  = flt_valid & flt_ready;
    assign last    = accept && (filter_cnt == nf_q - FW'(1));
    assign bad_cfg = num_kernel == '0 || num_kernel > KERNELNUM_WIDTH'(MAX_KERNELNUM) || num_filter == '0;
    pe_onehot_addr #(
        .MAX_FILTERNUM(MAX_FILTERNUM),
        .MAX_KERNELNUM(MAX_KERNELNUM),
        .W            (FW)
    ) u_addr (
        .row   (row),
        .kern  (kern),
        .en    (accept),
        .onehot(we_nxt)
    );
    // next-state logic; CHECK divides by repeated subtraction, one step per cycle
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? (bad_cfg ? ERR : CHECK) : IDLE;
            CHECK:   nxt = (rows + FW'(1) > ROWS_MAX || rem < nk_q) ? ERR : (rem == nk_q ? LOAD : CHECK);
            ERR:     nxt = IDLE;
            LOAD:    nxt = last ? COMPUTE : LOAD;
            COMPUTE: nxt = compute_done ? DONE : COMPUTE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // state, registered outputs decoded from the next state, and load datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            cfg_err       <= 1'b0;
            flt_ready     <= 1'b0;
            filter_load   <= 1'b0;
            compute_start <= 1'b0;
            done          <= 1'b0;
            pe_we         <= '0;
            pe_wdata      <= '0;
            filter_cnt    <= '0;
            nf_q          <= '0;
            nk_q          <= '0;
            rem           <= '0;
            rows          <= '0;
            row           <= '0;
            kern          <= '0;
        end else begin
            state         <= nxt;
            busy          <= nxt != IDLE;
            cfg_err       <= nxt == ERR;
            flt_ready     <= nxt == LOAD;
            filter_load   <= nxt == COMPUTE;
            compute_start <= nxt == COMPUTE && state != COMPUTE;
            done          <= nxt == DONE;
            pe_we         <= we_nxt;
            if (state == IDLE && start) begin
                nf_q       <= num_filter;
                nk_q       <= FW'(num_kernel);
                rem        <= num_filter;
                rows       <= '0;
                row        <= '0;
                kern       <= '0;
                filter_cnt <= '0;
            end
            if (state == CHECK) begin
                rem  <= rem - nk_q;
                rows <= rows + FW'(1);
            end
            if (accept) begin
                pe_wdata   <= flt_data;
                filter_cnt <= filter_cnt + FW'(1);
                kern       <= (kern == nk_q - FW'(1)) ? '0 : kern + FW'(1);
                row        <= (kern == nk_q - FW'(1)) ? row + FW'(1) : row;
            end
            if (nxt == DONE) begin
                filter_cnt <= '0;
                row        <= '0;
                kern       <= '0;
            end
        end
    end
endmodule
